// File: rtl/sqrt_fx_iter.sv
// Fixed-point square root using a radix-2 restoring digit recurrence.
// The root is floor(sqrt(n * 4^FRAC_BITS)) and the remainder is exact.
module sqrt_fx_iter #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 0,
    parameter int UNROLL    = 1,
    parameter int SIGNED_IN = 0,
    localparam int RW       = WIDTH / 2 + FRAC_BITS,
    localparam int ITER     = RW / UNROLL
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WIDTH-1:0] n,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] root,
    output logic [RW:0]   rem,
    output logic          neg,
    output logic          busy
);
    localparam int SW = WIDTH + 2 * FRAC_BITS;
    localparam int CW = $clog2(ITER + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [SW-1:0] sh;
    logic [RW-1:0] q;
    logic [RW+1:0] r;
    logic [CW-1:0] cnt;

    logic [SW-1:0] n_ext;
    logic [SW-1:0] sh_n;
    logic [RW-1:0] q_n;
    logic [RW+1:0] r_n;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; the producer holds its data stable until that edge.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC);

    assign n_ext = SW'(n) << (2 * FRAC_BITS);

    // UNROLL recurrence steps chained in one cycle.
    always_comb begin
        logic [RW+1:0] rp;
        logic [RW+1:0] t;
        sh_n = sh;
        q_n  = q;
        r_n  = r;
        rp   = '0;
        t    = '0;
        for (int i = 0; i < UNROLL; i++) begin
            // r stays below 2^RW before the last step, so dropping its top bits is lossless.
            rp   = {r_n[RW-1:0], sh_n[SW-1 -: 2]};
            sh_n = sh_n << 2;
            t    = {q_n, 2'b01};
            if (rp >= t) begin
                r_n = rp - t;
                q_n = {q_n[RW-2:0], 1'b1};
            end else begin
                r_n = rp;
                q_n = {q_n[RW-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            sh    <= '0;
            q     <= '0;
            r     <= '0;
            cnt   <= '0;
            root  <= '0;
            rem   <= '0;
            neg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh  <= n_ext;
                        q   <= '0;
                        r   <= '0;
                        cnt <= CW'(ITER);
                        if (SIGNED_IN != 0 && n[WIDTH-1]) begin
                            neg   <= 1'b1;
                            root  <= '0;
                            rem   <= '0;
                            state <= DONE;
                        end else begin
                            neg   <= 1'b0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    sh  <= sh_n;
                    q   <= q_n;
                    r   <= r_n;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        root  <= q_n;
                        rem   <= r_n[RW:0];
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sqrt_fx_iter.md
Name: sqrt_fx_iter

Overview:
- Parametrised fixed-point square-root unit. Successor to the single-precision Babylonian sqrt used in the collision datapath.
- Replaces the chain of iterative FP adder/divider instances with a radix-2 digit-recurrence (restoring) core.
- Gives deterministic latency, a valid/ready handshake on both sides, a remainder output, and an optional signed-input mode with a negative-input flag.
- Sits between the distance-squared accumulator and the collision comparator.

Parameters:
- WIDTH, 32: radicand width in bits. Must be even, 8 to 64.
- FRAC_BITS, 0: fractional bits produced in the root. The radicand is internally left-shifted by 2*FRAC_BITS.
- UNROLL, 1: root bits resolved per clock. Legal values are 1 and 2. RW must be divisible by UNROLL.
- SIGNED_IN, 0: 1 means n is two's complement and negative inputs are flagged.
- Derived (localparam, not overridable): RW = WIDTH/2 + FRAC_BITS, the root width. ITER = RW/UNROLL.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous reset, active-high.
- in_valid  in  1  n is valid this cycle.
- in_ready  out  1  block can accept n.
- n  in  WIDTH  radicand.
- out_valid  out  1  root/rem/neg are valid.
- out_ready  in  1  consumer accepts the result.
- root  out  RW  floor(sqrt(n * 4^FRAC_BITS)).
- rem  out  RW+1  n*4^FRAC_BITS - root^2.
- neg  out  1  input was negative (SIGNED_IN=1 only); root=0, rem=0.
- busy  out  1  high in CALC.

Behaviour:
- Reset (RST=1, asynchronous):
  - state=IDLE.
  - in_ready=1, out_valid=0, root=0, rem=0, neg=0, busy=0.
  - All internal shift/remainder registers are cleared.
  - RST asserted mid-CALC or in DONE discards the operation. No output is produced for it.
- States: IDLE, CALC, DONE. in_ready = (state==IDLE). Outputs are registered.
- IDLE:
  - On in_valid & in_ready, capture R = {n, 2*FRAC_BITS zeros} into a shift register of width WIDTH+2*FRAC_BITS.
  - Clear the partial root q and partial remainder r; load iteration counter = ITER.
  - If SIGNED_IN=1 and n[WIDTH-1]=1, go to DONE with neg=1, root=0, rem=0 (latency 1).
  - Otherwise go to CALC with neg=0.
- CALC, per resolved bit (UNROLL steps chained combinationally in one cycle):
  - r' = (r << 2) | top two bits of R, then R <<= 2.
  - t = (q << 2) | 1.
  - If r' >= t (unsigned): r = r' - t, q = (q << 1) | 1. Otherwise r = r', q = q << 1.
  - r is held RW+2 bits wide, so intermediates never overflow.
  - Counter decrements by 1 per cycle. When it reaches 0 after the update, load root=q and rem=r[RW:0], then go to DONE.
- DONE:
  - out_valid=1. root, rem, neg are stable while out_valid & !out_ready.
  - On out_ready, the next cycle has out_valid=0 and state=IDLE.
  - in_ready rises the cycle after the handshake. No input is accepted in the same cycle as out_ready.
- Latency, from the accepting edge to the out_valid edge: ITER+1 cycles for normal inputs, 1 cycle for negative inputs.
  - Example: WIDTH=32, FRAC_BITS=0, UNROLL=1 gives 17 cycles.
- Throughput: one result per ITER+2 cycles when out_ready is held high.
- in_valid while in_ready=0 is ignored. The source must hold n until the handshake.
- Arithmetic is exact: root^2 <= N < (root+1)^2, and rem <= 2*root.
- Edge cases:
  - n=0 gives root=0, rem=0 with full latency; there is no early exit.
  - With SIGNED_IN=0, the full unsigned range is legal.

Test Plan:
- WIDTH=32, FRAC_BITS=0, UNROLL=1: n=16 -> root=4, rem=0; n=17 -> root=4, rem=1. out_valid exactly 17 cycles after accept; busy high for 16 cycles.
- n=0xFFFFFFFF -> root=65535 (0xFFFF), rem=131070 (0x1FFFE). n=0 -> root=0, rem=0, still 17 cycles.
- FRAC_BITS=8: n=2 -> root=362 (0x16A, about 1.414 in Q8), rem=28. UNROLL=2, n=16 -> root=0x400, rem=0, out_valid 13 cycles after accept.
- SIGNED_IN=1: n=0x80000000 -> neg=1, root=0, rem=0, out_valid 1 cycle after accept. n=0x00000009 -> neg=0, root=3.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout. Pulse out_ready -> out_valid falls next cycle, in_ready=1.
- Assert RST for 1 cycle at CALC cycle 5 -> all outputs at reset values immediately. A new n=81 afterwards -> root=9, rem=0, with no stale result emitted.
